// File: rtl/convolution3_pkg.sv
// Shared constants and engine state type for the 3x3 convolution accelerator.
package convolution3_pkg;

  // Control register word addresses (top of the host address space)
  localparam int CLEAR_ADDR        = 'h3FFD;
  localparam int START_ADDR        = 'h3FFE;
  localparam int DONE_ADDR         = 'h3FFF;

  // Job layout: weights then activations, 9 taps x 8 channel words each
  localparam int JOB_STRIDE        = 144;
  localparam int WORDS_PER_OPERAND = 72;

  // Accumulator never narrower than this, even if the math would allow it
  localparam int ACC_MIN_W         = 18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STORE,
    ST_DONE
  } eng_state_e;

  // $clog2 that never returns 0, so counters keep at least one bit
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_mac8.sv
// Combinational lane-parallel unsigned multiply with a pairwise adder tree.
// NUM_LANES must be a power of two.
module conv_mac8 #(
  parameter int DATA_WIDTH      = 32,
  parameter int PRECISION_WIDTH = 4,
  parameter int SUM_W           = 11
) (
  input  logic [DATA_WIDTH-1:0] w_word,
  input  logic [DATA_WIDTH-1:0] a_word,
  output logic [SUM_W-1:0]      sum
);

  localparam int NUM_LANES = DATA_WIDTH / PRECISION_WIDTH;

  logic [NUM_LANES-1:0][SUM_W-1:0] prod;

  // Operands are widened before the multiply so the product is not truncated
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign prod[l] = SUM_W'(w_word[l*PRECISION_WIDTH +: PRECISION_WIDTH]) *
                     SUM_W'(a_word[l*PRECISION_WIDTH +: PRECISION_WIDTH]);
  end

  // Pairwise reduction: each level halves the number of live partial sums
  always_comb begin
    logic [SUM_W-1:0] node [NUM_LANES];
    for (int i = 0; i < NUM_LANES; i++) node[i] = prod[i];
    for (int span = NUM_LANES / 2; span > 0; span = span / 2) begin
      for (int n = 0; n < span; n++) node[n] = node[2*n] + node[2*n+1];
    end
    sum = node[0];
  end

endmodule

// File: rtl/convolution3_mem_if.sv
// Memory-mapped 3x3 convolution accelerator: host loads packed weights and
// activations, pulses START, polls DONE, then reads one dot product per job.
module convolution3_mem_if
  import convolution3_pkg::*;
#(
  parameter int PRECISION_WIDTH  = 4,
  parameter int VALID_ADDR_WIDTH = 14,
  parameter int DATA_WIDTH       = 32,
  parameter int KERNEL_NUM       = 128,
  parameter int JOB_NUM          = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_we,
  input  logic                        i_re,
  input  logic [VALID_ADDR_WIDTH-1:0] i_write_addr,
  input  logic [VALID_ADDR_WIDTH-1:0] i_read_addr,
  input  logic [DATA_WIDTH-1:0]       i_data,
  output logic [DATA_WIDTH-1:0]       o_data
);

  localparam int NUM_LANES   = DATA_WIDTH / PRECISION_WIDTH;
  localparam int SUM_W       = 2 * PRECISION_WIDTH + clog2_min1(NUM_LANES);
  localparam int ACC_NEED    = SUM_W + clog2_min1(WORDS_PER_OPERAND);
  localparam int ACC_W       = (ACC_NEED > ACC_MIN_W) ? ACC_NEED : ACC_MIN_W;
  localparam int BUF_WORDS   = JOB_STRIDE * JOB_NUM;
  localparam int RESULT_BASE = BUF_WORDS;
  localparam int BUF_AW      = clog2_min1(BUF_WORDS);
  localparam int RES_AW      = clog2_min1(KERNEL_NUM);
  localparam int IDX_W       = clog2_min1(WORDS_PER_OPERAND);
  localparam int JOB_W       = clog2_min1(JOB_NUM);

  localparam logic [VALID_ADDR_WIDTH-1:0] BUF_END_A  = VALID_ADDR_WIDTH'(BUF_WORDS);
  localparam logic [VALID_ADDR_WIDTH-1:0] RES_BASE_A = VALID_ADDR_WIDTH'(RESULT_BASE);
  localparam logic [VALID_ADDR_WIDTH-1:0] RES_END_A  = VALID_ADDR_WIDTH'(RESULT_BASE + KERNEL_NUM);
  localparam logic [VALID_ADDR_WIDTH-1:0] CLR_A      = VALID_ADDR_WIDTH'(CLEAR_ADDR);
  localparam logic [VALID_ADDR_WIDTH-1:0] START_A    = VALID_ADDR_WIDTH'(START_ADDR);
  localparam logic [VALID_ADDR_WIDTH-1:0] DONE_A     = VALID_ADDR_WIDTH'(DONE_ADDR);

  // Storage: job buffer (weights + activations) and the clearable result region
  logic [DATA_WIDTH-1:0] job_mem [BUF_WORDS];
  logic [DATA_WIDTH-1:0] res_mem [KERNEL_NUM];

  // Engine state
  eng_state_e        state;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]  idx;
  logic [JOB_W-1:0]  job;
  logic [BUF_AW-1:0] job_base;

  // Host address decode
  logic              wr_in_job, wr_in_res, rd_in_job, rd_in_res;
  logic [BUF_AW-1:0] wr_buf_idx, rd_buf_idx;
  logic [RES_AW-1:0] wr_res_idx, rd_res_idx;
  logic              host_wr_ok, start_fire, clear_fire;

  assign wr_in_job  = (i_write_addr < BUF_END_A);
  assign wr_in_res  = (i_write_addr >= RES_BASE_A) && (i_write_addr < RES_END_A);
  assign rd_in_job  = (i_read_addr < BUF_END_A);
  assign rd_in_res  = (i_read_addr >= RES_BASE_A) && (i_read_addr < RES_END_A);
  assign wr_buf_idx = BUF_AW'(i_write_addr);
  assign rd_buf_idx = BUF_AW'(i_read_addr);
  assign wr_res_idx = RES_AW'(i_write_addr - RES_BASE_A);
  assign rd_res_idx = RES_AW'(i_read_addr - RES_BASE_A);

  // Memory-region writes are locked out for the whole run, including STORE/DONE
  assign host_wr_ok = i_we && !busy;
  assign start_fire = i_we && (i_write_addr == START_A) && i_data[0] && (state == ST_IDLE);
  assign clear_fire = host_wr_ok && (i_write_addr == CLR_A) && i_data[0];

  // Engine operand fetch: two combinational read ports into the job buffer
  logic [BUF_AW-1:0]     w_idx, a_idx;
  logic [DATA_WIDTH-1:0] w_word, a_word;
  logic [SUM_W-1:0]      mac_sum;
  logic [RES_AW-1:0]     res_idx;

  assign w_idx   = job_base + BUF_AW'(idx);
  assign a_idx   = w_idx + BUF_AW'(WORDS_PER_OPERAND);
  assign w_word  = job_mem[w_idx];
  assign a_word  = job_mem[a_idx];
  assign res_idx = RES_AW'(job);

  conv_mac8 #(
    .DATA_WIDTH      (DATA_WIDTH),
    .PRECISION_WIDTH (PRECISION_WIDTH),
    .SUM_W           (SUM_W)
  ) u_mac (
    .w_word (w_word),
    .a_word (a_word),
    .sum    (mac_sum)
  );

  // Job buffer host writes; contents deliberately survive reset
  always_ff @(posedge i_clk) begin
    if (i_rst_n && host_wr_ok && wr_in_job) job_mem[wr_buf_idx] <= i_data;
  end

  // Result region: CLEAR, host writes while idle, engine stores while busy.
  // Held off during reset so an aborted run leaves no partial result.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (clear_fire) begin
        for (int k = 0; k < KERNEL_NUM; k++) res_mem[k] <= '0;
      end else if (host_wr_ok && wr_in_res) begin
        res_mem[wr_res_idx] <= i_data;
      end else if (state == ST_STORE) begin
        res_mem[res_idx] <= DATA_WIDTH'(acc);
      end
    end
  end

  // Engine FSM: accumulate one word pair per RUN cycle, store per job, flag done
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc      <= '0;
      idx      <= '0;
      job      <= '0;
      job_base <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_fire) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            acc      <= '0;
            idx      <= '0;
            job      <= '0;
            job_base <= '0;
          end else if (clear_fire) begin
            done <= 1'b0;
          end
        end
        ST_RUN: begin
          acc <= acc + ACC_W'(mac_sum);
          idx <= idx + 1'b1;
          if (idx == IDX_W'(WORDS_PER_OPERAND - 1)) state <= ST_STORE;
        end
        ST_STORE: begin
          acc <= '0;
          idx <= '0;
          if (job == JOB_W'(JOB_NUM - 1)) begin
            state <= ST_DONE;
          end else begin
            job      <= job + 1'b1;
            job_base <= job_base + BUF_AW'(JOB_STRIDE);
            state    <= ST_RUN;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered host read port; holds when i_re is low, old data on collision
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_data <= '0;
    end else if (i_re) begin
      if (rd_in_job)                  o_data <= job_mem[rd_buf_idx];
      else if (rd_in_res)             o_data <= res_mem[rd_res_idx];
      else if (i_read_addr == START_A) o_data <= {{(DATA_WIDTH-1){1'b0}}, busy};
      else if (i_read_addr == DONE_A)  o_data <= {{(DATA_WIDTH-1){1'b0}}, done};
      else                            o_data <= '0;
    end
  end

endmodule

// File: tb/tb_convolution3_mem_if.sv
// Directed bench: table of register-map vectors plus hand sequences for
// read latency, collisions, busy lockout, CLEAR, restart and mid-run reset.
module tb_convolution3_mem_if;

  localparam int LAT_MAX = 2 * 76 + 4;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_we;
  logic        i_re;
  logic [13:0] i_write_addr;
  logic [13:0] i_read_addr;
  logic [31:0] i_data;
  logic [31:0] o_data;

  int checks;
  int fails;

  convolution3_mem_if dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_we         (i_we),
    .i_re         (i_re),
    .i_write_addr (i_write_addr),
    .i_read_addr  (i_read_addr),
    .i_data       (i_data),
    .o_data       (o_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        wr;
    logic [13:0] addr;
    logic [31:0] data;  // write data, or expected read data
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // All host tasks start and end 1 time unit after a rising edge
  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    i_we = 1'b1; i_write_addr = a; i_data = d;
    @(posedge i_clk); #1;
    i_we = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] d);
    i_re = 1'b1; i_read_addr = a;
    @(posedge i_clk); #1;
    i_re = 1'b0;
    d = o_data;
  endtask

  task automatic rd_chk(input string nm, input logic [13:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(nm, d, exp);
  endtask

  // Poll DONE with a cycle budget; optionally poke the port while busy
  task automatic wait_done(input string nm, input bit inject);
    logic [31:0] d;
    int cyc;
    bit got;
    cyc = 0; got = 0;
    while (!got && cyc < 400) begin
      if (inject && cyc == 10) begin
        wr(14'd0, 32'hFFFF_FFFF);
        wr(14'h3FFE, 32'd1);
        cyc += 2;
      end
      rd(14'h3FFF, d);
      cyc++;
      if (d[0]) got = 1;
    end
    chk({nm, "_seen"}, {31'b0, got}, 32'd1);
    chk({nm, "_latency_ok"}, {31'b0, (cyc <= LAT_MAX + 1)}, 32'd1);
  endtask

  task automatic load_jobs();
    for (int j = 0; j < 2; j++) begin
      for (int g = 0; g < 8; g++)
        for (int k = 0; k < 9; k++)
          wr(14'(144*j + 9*g + k), (k % 2) ? 32'h9ABC_DEF0 : 32'h1234_5678);
      for (int m = 0; m < 72; m++)
        wr(14'(144*j + 72 + m), (j == 1) ? 32'h2222_2222 : 32'h1111_1111);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    checks = 0; fails = 0;

    tbl[0]  = '{1'b0, 14'h120,  32'h0000_1020};
    tbl[1]  = '{1'b0, 14'h121,  32'h0000_2040};
    tbl[2]  = '{1'b0, 14'h122,  32'h0000_0000};
    tbl[3]  = '{1'b0, 14'h3FFF, 32'h0000_0001};
    tbl[4]  = '{1'b0, 14'h3FFE, 32'h0000_0000};
    tbl[5]  = '{1'b0, 14'd0,    32'h1234_5678};
    tbl[6]  = '{1'b0, 14'd72,   32'h1111_1111};
    tbl[7]  = '{1'b0, 14'd216,  32'h2222_2222};
    tbl[8]  = '{1'b1, 14'h3FFF, 32'h0000_0000};
    tbl[9]  = '{1'b0, 14'h3FFF, 32'h0000_0001};
    tbl[10] = '{1'b1, 14'h3FFD, 32'h0000_0002};
    tbl[11] = '{1'b0, 14'h3FFF, 32'h0000_0001};
    tbl[12] = '{1'b0, 14'h120,  32'h0000_1020};
    tbl[13] = '{1'b1, 14'h3000, 32'hDEAD_BEEF};
    tbl[14] = '{1'b0, 14'h3000, 32'h0000_0000};
    tbl[15] = '{1'b0, 14'h1A0,  32'h0000_0000};
    tbl[16] = '{1'b0, 14'h184,  32'h0000_0000};
    tbl[17] = '{1'b0, 14'h19F,  32'h0000_0000};

    i_rst_n = 1'b0; i_we = 1'b0; i_re = 1'b0;
    i_write_addr = '0; i_read_addr = '0; i_data = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_odata", o_data, 32'h0);
    i_rst_n = 1'b1;
    rd_chk("reset_busy", 14'h3FFE, 32'h0);
    rd_chk("reset_done", 14'h3FFF, 32'h0);

    // Read latency and hold
    wr(14'd5, 32'hA5A5_A5A5);
    rd_chk("rd_unmapped_pre", 14'h3000, 32'h0);
    i_re = 1'b1; i_read_addr = 14'd5;
    @(negedge i_clk);
    chk("lat_before_edge", o_data, 32'h0);
    @(posedge i_clk); #1;
    i_re = 1'b0;
    chk("lat_one_edge", o_data, 32'hA5A5_A5A5);
    i_read_addr = 14'h3FFF;
    repeat (3) @(posedge i_clk);
    #1;
    chk("lat_hold", o_data, 32'hA5A5_A5A5);

    // Same-address write/read collision returns the old word
    wr(14'h184, 32'h1357_9BDF);
    i_we = 1'b1; i_write_addr = 14'h184; i_data = 32'h5A5A_5A5A;
    i_re = 1'b1; i_read_addr = 14'h184;
    @(posedge i_clk); #1;
    i_we = 1'b0; i_re = 1'b0;
    chk("collision_old", o_data, 32'h1357_9BDF);
    rd_chk("collision_new", 14'h184, 32'h5A5A_5A5A);

    // First run, with a write and a second START injected while busy
    wr(14'h3FFD, 32'd1);
    load_jobs();
    wr(14'h3FFD, 32'd0);
    wr(14'h3FFE, 32'd1);
    rd_chk("busy_after_start", 14'h3FFE, 32'd1);
    wait_done("run1", 1'b1);

    for (int v = 0; v < 18; v++) begin
      if (tbl[v].wr) wr(tbl[v].addr, tbl[v].data);
      else begin
        rd(tbl[v].addr, d);
        chk($sformatf("vec%0d", v), d, tbl[v].data);
      end
    end

    // CLEAR then rerun
    wr(14'h3FFD, 32'd1);
    rd_chk("clear_done", 14'h3FFF, 32'h0);
    rd_chk("clear_res0", 14'h120, 32'h0);
    rd_chk("clear_res1", 14'h121, 32'h0);
    wr(14'h3FFE, 32'd1);
    wait_done("run2", 1'b0);
    rd_chk("rerun_res0", 14'h120, 32'h0000_1020);
    rd_chk("rerun_res1", 14'h121, 32'h0000_2040);

    // START with done already set clears it on the launch edge
    wr(14'h3FFE, 32'd1);
    rd_chk("start_clears_done", 14'h3FFF, 32'h0);
    rd_chk("restart_busy", 14'h3FFE, 32'd1);
    wait_done("run3", 1'b0);
    rd_chk("run3_res0", 14'h120, 32'h0000_1020);

    // Reset mid-run aborts without writing a result
    wr(14'h3FFD, 32'd1);
    wr(14'h3FFE, 32'd1);
    repeat (10) @(posedge i_clk);
    #1;
    rd_chk("midrun_busy", 14'h3FFE, 32'd1);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    chk("rst_odata", o_data, 32'h0);
    rd_chk("rst_busy", 14'h3FFE, 32'h0);
    rd_chk("rst_done", 14'h3FFF, 32'h0);
    repeat (200) @(posedge i_clk);
    #1;
    rd_chk("rst_res0", 14'h120, 32'h0);
    rd_chk("rst_res1", 14'h121, 32'h0);
    rd_chk("rst_done_late", 14'h3FFF, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/convolution3_mem_if.md
Name: convolution3_mem_if

Overview:
Memory-mapped 3x3 convolution accelerator with a simple word-addressed host port.
- The host writes packed 4-bit weights and activations into an internal word buffer, then pulses a start register.
- An internal engine computes one dot product per job and writes the 32-bit results into a result region.
- The host polls a done register, then reads the results back through the same port.

Parameters:
- PRECISION_WIDTH, 4: bits per element. Elements are unsigned; DATA_WIDTH/PRECISION_WIDTH = 8 elements per word.
- VALID_ADDR_WIDTH, 14: host address width in words.
- DATA_WIDTH, 32: host data width.
- KERNEL_NUM, 128: depth in words of the result region.
- JOB_NUM, 2: number of jobs. Each job is 72 weight words followed by 72 activation words, so 9 words x 8 channels per operand.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_we  in  1  write enable; one word written per cycle.
- i_re  in  1  read enable.
- i_write_addr  in  VALID_ADDR_WIDTH  write word address.
- i_read_addr  in  VALID_ADDR_WIDTH  read word address.
- i_data  in  DATA_WIDTH  write data.
- o_data  out  DATA_WIDTH  registered read data.

Behaviour:
Address map (word addresses):
- Job k, for k < JOB_NUM:
  - weights at 144k .. 144k+71;
  - activations at 144k+72 .. 144k+143.
- RESULT_BASE = 144*JOB_NUM (0x120 by default). Results occupy RESULT_BASE .. RESULT_BASE+KERNEL_NUM-1; result k is at RESULT_BASE+k.
- 0x3FFD CLEAR: a write with bit0=1 clears done and zeroes all result words. A write with bit0=0 is a no-op.
- 0x3FFE START: a write with bit0=1 while idle launches the engine. It is a self-clearing pulse. A read returns {0, busy}.
- 0x3FFF DONE: a read returns {31'b0, done}. Writes are ignored.
- Any other address: reads return 0; writes are dropped.

Host port:
- Writes commit on the rising edge where i_we=1.
- Reads: when i_re=1, o_data is updated on the next edge with the contents at i_read_addr. Latency is 1 cycle.
- When i_re=0, o_data holds its value.
- i_we and i_re may be active in the same cycle. For a same-address collision, the read returns the old data.
- While busy, host writes to the job and result regions are dropped. CLEAR is also ignored while busy. Reads are always serviced.

Engine FSM: IDLE -> RUN -> STORE -> (next job ? RUN : DONE) -> IDLE.
- RUN: each cycle, read weight word w and activation word a at the same index. Add sum over 8 lanes of w[4i+3:4i]*a[4i+3:4i] (unsigned) to the accumulator, for 72 cycles.
- The weight and activation words are read through two internal read ports.
- STORE: write the zero-extended accumulator (minimum 18 bits) to RESULT_BASE+k, then clear the accumulator.
- DONE: set done=1, clear busy, return to IDLE.
- Latency from the START write edge to done=1 is at most JOB_NUM*(72+4)+4 cycles.
- done stays high until CLEAR, a new START, or reset. A new START clears done in the same edge it launches.

Reset:
- o_data=0, done=0, busy=0, FSM=IDLE, accumulator=0.
- Buffer contents are not reset.
- Reset asserted mid-run aborts the job; no partial result is written.

Decomposition:
- Package convolution3_pkg holds:
  - address constants: CLEAR_ADDR=0x3FFD, START_ADDR=0x3FFE, DONE_ADDR=0x3FFF, JOB_STRIDE=144, WORDS_PER_OPERAND=72;
  - an FSM state enum.
- Sub-module conv_mac8: purely combinational 8-lane unsigned 4x4 multiply with an adder tree. It takes two DATA_WIDTH words and produces an 11-bit sum.

Test Plan:
- Job 0 setup: write each 9-word group i=0..7 with alternating 0x12345678 / 0x9ABCDEF0 at addresses 9i..9i+8. Write 0x11111111 to 72..143. Write CLEAR=0, then START=1. Poll 0x3FFF until 1. Reading 0x120 returns 0x00001020 (4128).
- Job 1 setup: the same weights at 144..215 and 0x22222222 at 216..287. After the same run, reading 0x121 returns 0x00002040.
- Read latency: write 0xA5A5A5A5 to address 5, then read address 5. o_data equals 0xA5A5A5A5 exactly one edge after i_re and stays stable while i_re=0.
- Busy protection: during a run, write 0xFFFFFFFF to address 0 and pulse START again. Results are unchanged: 0x1020 and 0x2040.
- CLEAR: after done, write 1 to 0x3FFD. 0x3FFF reads 0 and 0x120 reads 0. A rerun reproduces 0x1020.
- Reset mid-run: assert i_rst_n=0 for one edge during RUN. o_data=0, 0x3FFE reads 0, 0x3FFF reads 0, and no result is written.
